// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive sampling path.
//   SAMPLES_MAX      largest supported vote count per bit
//   SYNC_STAGES      depth of the optional RX input synchronizer
//   PRESCALE_MARGIN  clocks per bit required beyond the vote window
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int SAMPLES_MAX     = 7;
    localparam int SYNC_STAGES     = 2;
    localparam int PRESCALE_MARGIN = 2;

    // Smallest legal prescale for a given vote count: the vote window must
    // fit inside the bit with room to register the result.
    function automatic int min_prescale(input int samples);
        return samples + PRESCALE_MARGIN;
    endfunction

endpackage

// File: rtl/majority_sampler_if.sv
// ---------------------------------------------------------------------------
// majority_sampler_if
// Bundles the sampler's RX input, control and result signals.
//   serial_data_in  RX line
//   prescale        clocks per bit (latched by the sampler)
//   enable          sampler active while high
//   align           one-cycle pulse restarting bit timing
//   sampled_bit     majority-vote result
//   bit_valid       one-cycle strobe qualifying sampled_bit
//   noise_flag      votes were not unanimous (with bit_valid)
//   cfg_err         latched prescale is illegal
// Modports: master drives the inputs, slave is the sampler.
// ---------------------------------------------------------------------------
interface majority_sampler_if #(
    parameter int PRESCALE_W = 6
) ();

    logic                  serial_data_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  enable;
    logic                  align;
    logic                  sampled_bit;
    logic                  bit_valid;
    logic                  noise_flag;
    logic                  cfg_err;

    modport master (
        output serial_data_in, prescale, enable, align,
        input  sampled_bit, bit_valid, noise_flag, cfg_err
    );

    modport slave (
        input  serial_data_in, prescale, enable, align,
        output sampled_bit, bit_valid, noise_flag, cfg_err
    );

endinterface

// File: rtl/sample_voter.sv
// ---------------------------------------------------------------------------
// sample_voter
// Combinational majority vote over SAMPLES captured line samples.
//   votes        captured samples, one bit per slot
//   sampled_bit  1 when at least (SAMPLES+1)/2 slots are 1
//   unanimous    1 when all slots agree
// ---------------------------------------------------------------------------
module sample_voter
    import uart_pkg::*;
#(
    parameter int SAMPLES = 3
) (
    input  logic [SAMPLES-1:0] votes,
    output logic               sampled_bit,
    output logic               unanimous
);

    localparam int CNT_W = $clog2(SAMPLES_MAX + 1);

    logic [CNT_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            ones = ones + CNT_W'(votes[k]);
        end
    end

    assign sampled_bit = (ones >= CNT_W'((SAMPLES + 1) / 2));
    assign unanimous   = (votes == '0) || (votes == '1);

endmodule

// File: rtl/majority_sampler.sv
// ---------------------------------------------------------------------------
// majority_sampler
// Oversampling RX bit sampler. An edge counter runs 0..P-1 per bit, SAMPLES
// line samples are taken around mid-bit and majority-voted into sampled_bit.
//   clk    clock, all logic on the rising edge
//   reset  synchronous, active-low
//   bus    majority_sampler_if.slave (RX line, prescale, enable, align,
//          sampled_bit, bit_valid, noise_flag, cfg_err)
// Optional build macro SAMPLER_SYNC_EN: serial_data_in passes through a
// 2-flop synchronizer (reset to idle-high) before capture.
// ---------------------------------------------------------------------------
module majority_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int SAMPLES    = 3
) (
    input  logic clk,
    input  logic reset,
    majority_sampler_if.slave bus
);

    localparam int            CW        = PRESCALE_W + 1;
    localparam logic [CW-1:0] HALF_SPAN = CW'((SAMPLES - 1) >> 1);
    localparam logic [CW-1:0] N_SAMPLES = CW'(SAMPLES);
    localparam logic [CW-1:0] MIN_P     = CW'(min_prescale(SAMPLES));

    logic din;

`ifdef SAMPLER_SYNC_EN
    // Input synchronizer stage
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.serial_data_in};
        end
    end

    assign din = sync_q[SYNC_STAGES-1];
`else
    assign din = bus.serial_data_in;
`endif

    logic [PRESCALE_W-1:0] p_q;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  en_q;
    logic                  cfg_err_q;
    logic                  sampled_q;
    logic                  valid_q;
    logic                  noise_q;
    logic [SAMPLES-1:0]    votes_q;
    logic [SAMPLES-1:0]    votes_nxt;

    logic                  load;
    logic                  run;
    logic                  vote_now;
    logic                  vote_bit;
    logic                  vote_unan;
    logic [PRESCALE_W-1:0] p_now;
    logic [CW-1:0]         cnt_x;
    logic [CW-1:0]         cnt_inc;
    logic [CW-1:0]         first_idx;

    // Prescale is (re)latched on the first enabled cycle and on align; the
    // new value already governs this cycle's wrap decision.
    assign load    = bus.enable && (!en_q || bus.align);
    assign p_now   = load ? bus.prescale : p_q;
    // Captures are suppressed while latching: align must win, and on the
    // first enabled cycle p_q is not yet valid.
    assign run     = bus.enable && !load && !cfg_err_q;

    assign cnt_x     = {1'b0, edge_cnt};
    assign cnt_inc   = cnt_x + CW'(1);
    assign first_idx = ({1'b0, p_q} >> 1) - HALF_SPAN;

    // Capture window: slot k is written when edge_cnt == first_idx + k. The
    // last slot is fed straight to the voter so the result registers on the
    // same edge.
    always_comb begin
        votes_nxt = votes_q;
        vote_now  = 1'b0;
        if (run) begin
            for (int k = 0; k < SAMPLES; k++) begin
                if (cnt_x == first_idx + CW'(k)) begin
                    votes_nxt[k] = din;
                end
            end
            vote_now = (cnt_x == first_idx + N_SAMPLES - CW'(1));
        end
    end

    sample_voter #(
        .SAMPLES (SAMPLES)
    ) u_voter (
        .votes       (votes_nxt),
        .sampled_bit (vote_bit),
        .unanimous   (vote_unan)
    );

    // Counter, latch, capture and output register stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q       <= '0;
            edge_cnt  <= '0;
            en_q      <= 1'b0;
            cfg_err_q <= 1'b0;
            sampled_q <= 1'b0;
            valid_q   <= 1'b0;
            noise_q   <= 1'b0;
            votes_q   <= '0;
        end else begin
            en_q    <= bus.enable;
            valid_q <= 1'b0;
            noise_q <= 1'b0;
            if (!bus.enable) begin
                edge_cnt <= '0;
                votes_q  <= '0;
            end else begin
                if (load) begin
                    p_q       <= bus.prescale;
                    cfg_err_q <= ({1'b0, bus.prescale} < MIN_P);
                end
                if (bus.align) begin
                    edge_cnt <= '0;
                    votes_q  <= '0;
                end else begin
                    edge_cnt <= (cnt_inc >= {1'b0, p_now}) ? '0 : cnt_inc[PRESCALE_W-1:0];
                    votes_q  <= votes_nxt;
                    if (vote_now) begin
                        sampled_q <= vote_bit;
                        valid_q   <= 1'b1;
                        noise_q   <= !vote_unan;
                    end
                end
            end
        end
    end

    assign bus.sampled_bit = sampled_q;
    assign bus.bit_valid   = valid_q;
    assign bus.noise_flag  = noise_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_majority_sampler.sv
// ---------------------------------------------------------------------------
// tb_majority_sampler
// Directed bench for majority_sampler: instance A (SAMPLES=3) covers timing,
// voting, noise, illegal prescale, align, enable and reset; instance B
// (SAMPLES=5, P=16) covers a ten-bit stream.
// ---------------------------------------------------------------------------
module tb_majority_sampler;

    logic clk;
    logic reset;

    majority_sampler_if #(.PRESCALE_W(6)) ifa ();
    majority_sampler_if #(.PRESCALE_W(6)) ifb ();

    majority_sampler #(.PRESCALE_W(6), .SAMPLES(3)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    majority_sampler #(.PRESCALE_W(6), .SAMPLES(5)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   viol    = 0;
    int   nstb;
    int   fstb;
    logic sdat;
    logic snoise;
    logic last_sb;
    logic prev_vld = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles on instance A. Cycle i drives serial_data_in = pat[i] and
    // optionally align in cycle 0; strobes are recorded by cycle index.
    task automatic run_a(input int n, input logic [31:0] pat, input logic align_first);
        nstb = 0;
        fstb = -1;
        sdat = 1'b0;
        snoise = 1'b0;
        for (int i = 0; i < n; i++) begin
            ifa.serial_data_in = pat[i];
            ifa.align = align_first && (i == 0);
            if (ifa.bit_valid) begin
                nstb++;
                if (fstb < 0) fstb = i;
                sdat = ifa.sampled_bit;
                snoise = ifa.noise_flag;
            end
            if (!ifa.bit_valid && ifa.noise_flag) viol++;
            if (prev_vld && ifa.bit_valid) viol++;
            prev_vld = ifa.bit_valid;
            last_sb = ifa.sampled_bit;
            tick();
        end
        ifa.align = 1'b0;
    endtask

    initial begin
        int nb;
        reset = 1'b0;
        ifa.serial_data_in = 1'b1; ifa.prescale = 6'd8; ifa.enable = 1'b0; ifa.align = 1'b0;
        ifb.serial_data_in = 1'b1; ifb.prescale = 6'd16; ifb.enable = 1'b0; ifb.align = 1'b0;
        tick();
        tick();
        check_val("rst_sampled", 32'(ifa.sampled_bit), 0);
        check_val("rst_valid",   32'(ifa.bit_valid),   0);
        check_val("rst_noise",   32'(ifa.noise_flag),  0);
        check_val("rst_cfg_err", 32'(ifa.cfg_err),     0);

        // P=8: all-zero bit, strobe when edge_cnt reaches 6
        reset = 1'b1;
        ifa.enable = 1'b1;
        run_a(8, 32'h0, 1'b0);
        check_val("zero_nstb",  32'(nstb), 1);
        check_val("zero_time",  32'(fstb), 6);
        check_val("zero_data",  32'(sdat), 0);
        check_val("zero_noise", 32'(snoise), 0);

        // Ones with a single 0 at edge_cnt 4
        run_a(8, 32'hEF, 1'b0);
        check_val("glitch_time",  32'(fstb), 6);
        check_val("glitch_data",  32'(sdat), 1);
        check_val("glitch_noise", 32'(snoise), 1);
        check_val("glitch_hold",  32'(last_sb), 1);

        // Illegal prescale 4, then realign with 8
        ifa.prescale = 6'd4;
        run_a(16, 32'hFFFF, 1'b1);
        check_val("bad_p_nstb", 32'(nstb), 0);
        check_val("bad_p_cfg",  32'(ifa.cfg_err), 1);
        ifa.prescale = 6'd8;
        run_a(9, 32'h0, 1'b1);
        check_val("fix_p_cfg",   32'(ifa.cfg_err), 0);
        check_val("fix_p_nstb",  32'(nstb), 1);
        check_val("fix_p_time",  32'(fstb), 7);
        check_val("fix_p_data",  32'(sdat), 0);
        check_val("fix_p_noise", 32'(snoise), 0);

        // Align at edge_cnt 4 aborts the bit
        run_a(4, 32'h0, 1'b0);
        check_val("abort_pre", 32'(nstb), 0);
        run_a(9, 32'h1FF, 1'b1);
        check_val("abort_nstb", 32'(nstb), 1);
        check_val("abort_time", 32'(fstb), 7);
        check_val("abort_data", 32'(sdat), 1);

        // Enable dropped at edge_cnt 5, then re-enabled
        run_a(5, 32'h1F, 1'b0);
        check_val("en_pre", 32'(nstb), 0);
        ifa.enable = 1'b0;
        run_a(8, 32'hFF, 1'b0);
        check_val("en_off_nstb", 32'(nstb), 0);
        check_val("en_off_hold", 32'(last_sb), 1);
        ifa.enable = 1'b1;
        run_a(8, 32'h20, 1'b0);
        check_val("reen_time",  32'(fstb), 6);
        check_val("reen_data",  32'(sdat), 0);
        check_val("reen_noise", 32'(snoise), 1);

        // Prescale change without align is ignored
        ifa.prescale = 6'd12;
        run_a(8, 32'hFF, 1'b0);
        check_val("p_ignore_time", 32'(fstb), 6);
        check_val("p_ignore_data", 32'(sdat), 1);
        ifa.prescale = 6'd8;

        // Reset at edge_cnt 5 discards the bit
        run_a(5, 32'h1F, 1'b0);
        ifa.serial_data_in = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("mid_rst_sampled", 32'(ifa.sampled_bit), 0);
        check_val("mid_rst_valid",   32'(ifa.bit_valid), 0);
        run_a(6, 32'h3F, 1'b0);
        check_val("mid_rst_nstb", 32'(nstb), 0);
        check_val("mid_rst_sb",   32'(last_sb), 0);

        // Instance B: P=16, SAMPLES=5, stream 1010101010
        ifa.enable = 1'b0;
        ifb.enable = 1'b1;
        nb = 0;
        for (int i = 0; i < 170; i++) begin
            ifb.serial_data_in = ((i / 16) % 2) == 0;
            if (ifb.bit_valid) begin
                if (nb < 10) begin
                    check_val("strm_time", 32'(i), 32'(11 + 16 * nb));
                    check_val("strm_data", 32'(ifb.sampled_bit), 32'((nb % 2) == 0));
                end
                if (ifb.noise_flag) viol++;
                nb++;
            end
            tick();
        end
        check_val("strm_count", 32'(nb), 10);
        check_val("flag_rules", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/majority_sampler.md
MAJORITY_SAMPLER -- requirements
Module: majority_sampler

Interface
REQ-001 Parameter PRESCALE_W, default 6, width of prescale and internal edge counter.
REQ-002 Parameter SAMPLES, default 3, number of votes per bit; legal values are odd 1..7.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 serial_data_in  input  1  RX line.
REQ-006 prescale  input  PRESCALE_W  oversampling ratio, in clocks per bit.
REQ-007 enable  input  1  sampler active while high.
REQ-008 align  input  1  single-cycle pulse that restarts bit timing (start-edge detected).
REQ-009 sampled_bit  output  1  majority-vote result, registered.
REQ-010 bit_valid  output  1  one-cycle strobe qualifying sampled_bit.
REQ-011 noise_flag  output  1  high with bit_valid when the votes were not unanimous.
REQ-012 cfg_err  output  1  latched prescale is illegal.

Function
REQ-013 The internal edge_cnt SHALL count 0..P-1 while enabled, then wrap to 0, where P is the latched prescale.
- One full wrap is one bit period.
REQ-014 P SHALL be latched from prescale on the first enabled cycle and on every align; prescale changes at other times SHALL be ignored.
REQ-015 The first sample index SHALL be c = (P>>1) - ((SAMPLES-1)>>1).
- serial_data_in SHALL be captured into vote slot k in the cycle where edge_cnt == c+k, for k = 0..SAMPLES-1.
REQ-016 The vote SHALL be registered at the end of the cycle with edge_cnt == c+SAMPLES-1.
- sampled_bit, bit_valid=1 and noise_flag SHALL therefore be visible in the cycle where edge_cnt == c+SAMPLES.
REQ-017 sampled_bit = 1 iff the count of ones in the vote slots is at least (SAMPLES+1)/2.
- sampled_bit SHALL hold its value between strobes.
REQ-018 noise_flag SHALL be 1 iff the votes are neither all-0 nor all-1; it SHALL be 0 whenever bit_valid is 0.
REQ-019 P < SAMPLES+2 is illegal.
- cfg_err SHALL be set while illegal and cleared at the next legal latch.
- While cfg_err is set: no captures, bit_valid=0.
REQ-020 Align in any cycle: edge_cnt SHALL be 0 in the next cycle and partial votes SHALL be discarded.
- Align SHALL win over a simultaneous capture or vote.
- Align while enable=0 SHALL be ignored.
REQ-021 Enable deasserted: edge_cnt and votes SHALL clear next cycle, no bit_valid, sampled_bit held.
- Re-enable SHALL restart at edge_cnt=0.
REQ-022 bit_valid SHALL never be high in two consecutive cycles.

Reset
REQ-023 On reset=0 at a clock edge: edge_cnt=0, votes=0, sampled_bit=0, bit_valid=0, noise_flag=0, cfg_err=0, P=0.
- Reset mid-bit SHALL discard the bit with no strobe.

Configuration
REQ-024 Macro SAMPLER_SYNC_EN defined: serial_data_in SHALL pass through a 2-flop synchronizer reset to 1.
- All capture timing SHALL refer to the synchronized signal (+2 cycles of input latency).
REQ-025 SAMPLER_SYNC_EN undefined: serial_data_in SHALL be captured directly, with no added latency.

Structure
REQ-026 Package uart_pkg SHALL hold SAMPLES_MAX=7, SYNC_STAGES=2 and the min-prescale margin constant 2.
REQ-027 The combinational sub-module sample_voter (votes in -> sampled bit, unanimous out) SHALL implement the vote.
- majority_sampler SHALL hold the counter, latch, capture and output registers.

Verification
REQ-028 P=8, SAMPLES=3, input 0 whole bit -> captures at edge_cnt 3,4,5; bit_valid at edge_cnt 6 with sampled_bit=0, noise_flag=0.
REQ-029 P=8, SAMPLES=3, input 1 except 0 at edge_cnt 4 -> sampled_bit=1, noise_flag=1.
REQ-030 P=16, SAMPLES=5, 10 bits 1010101010 -> exactly 10 strobes, 16 cycles apart, data matches.
REQ-031 P=4, SAMPLES=3 -> cfg_err=1, no bit_valid.
- Then align with P=8 -> cfg_err=0 and normal strobes.
REQ-032 align at edge_cnt 4 (P=8, SAMPLES=3) -> edge_cnt=0 next cycle, no strobe for the aborted bit, next strobe 6 cycles later.
REQ-033 reset or enable low at edge_cnt 5 -> no strobe, sampled_bit=0 after reset or held after enable low.
- With SAMPLER_SYNC_EN, all REQ-028 strobe timing +2 cycles.
